// File: rtl/pulse_stretcher.sv
// ============================================================================
//  Module   : pulse_stretcher
//  Brief    : Stretches single-cycle event strobes into programmable-length
//             pulses with an enforced low gap; queue or retrigger handling.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_stretcher #(
   parameter int CNT_W  = 16,
   parameter int PEND_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_pulse,
   input  logic [CNT_W-1:0]  i_high_len,
   input  logic [CNT_W-1:0]  i_low_len,
   input  logic              i_mode,
   input  logic              i_abort,
   output logic              o_sig,
   output logic              o_busy,
   output logic              o_done,
   output logic [PEND_W-1:0] o_pend_cnt,
   output logic              o_overflow
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0]  c_cnt_one  = 1;
   localparam logic [PEND_W-1:0] c_pend_one = 1;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [PEND_W-1:0]   r_pend;
   logic                r_sig;
   logic                r_busy;
   logic                r_done;
   logic                r_overflow;

   state_t              w_state_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [PEND_W-1:0]   w_pend_nxt;
   logic                w_done_nxt;
   logic                w_ovf_nxt;
   logic                w_pend_inc;
   logic                w_pend_dec;
   logic [CNT_W-1:0]    w_high_load;
   logic [CNT_W-1:0]    w_low_load;

   // A zero length behaves as one cycle, so the counter load saturates at 0.
   assign w_high_load = (i_high_len == '0) ? '0 : i_high_len - c_cnt_one;
   assign w_low_load  = (i_low_len  == '0) ? '0 : i_low_len  - c_cnt_one;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = r_pend;
      w_done_nxt  = 1'b0;
      w_ovf_nxt   = 1'b0;
      w_pend_inc  = 1'b0;
      w_pend_dec  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (i_pulse) begin
               w_state_nxt = ST_HIGH;
               w_cnt_nxt   = w_high_load;
            end
         end
         ST_HIGH: begin
            // A retrigger is treated as a fresh HIGH entry and reloads the length.
            if (i_pulse && i_mode) begin
               w_cnt_nxt = w_high_load;
            end else if (r_cnt == '0) begin
               w_state_nxt = ST_GAP;
               w_cnt_nxt   = w_low_load;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - c_cnt_one;
            end
            w_pend_inc = i_pulse && !i_mode;
         end
         ST_GAP: begin
            if (i_pulse && i_mode) begin
               w_state_nxt = ST_HIGH;
               w_cnt_nxt   = w_high_load;
            end else if (r_cnt == '0) begin
               // A strobe in the final gap cycle queues behind existing entries.
               if (r_pend != '0) begin
                  w_state_nxt = ST_HIGH;
                  w_cnt_nxt   = w_high_load;
                  w_pend_dec  = 1'b1;
                  w_pend_inc  = i_pulse;
               end else if (i_pulse) begin
                  w_state_nxt = ST_HIGH;
                  w_cnt_nxt   = w_high_load;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_cnt_nxt  = r_cnt - c_cnt_one;
               w_pend_inc = i_pulse;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      if (w_pend_inc && !w_pend_dec) begin
         if (&r_pend) begin
            w_ovf_nxt = 1'b1;
         end else begin
            w_pend_nxt = r_pend + c_pend_one;
         end
      end else if (w_pend_dec && !w_pend_inc) begin
         w_pend_nxt = r_pend - c_pend_one;
      end

      if (i_abort) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
         w_pend_nxt  = '0;
         w_done_nxt  = 1'b0;
         w_ovf_nxt   = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_pend     <= '0;
         r_sig      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_pend     <= w_pend_nxt;
         r_sig      <= (w_state_nxt == ST_HIGH);
         r_busy     <= (w_state_nxt != ST_IDLE);
         r_done     <= w_done_nxt;
         r_overflow <= w_ovf_nxt;
      end
   end

   assign o_sig      = r_sig;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_pend_cnt = r_pend;
   assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
// ============================================================================
//  Module   : tb_pulse_stretcher
//  Brief    : Directed and randomized checks of pulse_stretcher against a
//             remaining-cycles reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pulse_stretcher;

   localparam int CNT_W  = 16;
   localparam int PEND_W = 2;
   localparam int PMAX   = (1 << PEND_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              pulse, mode, abort;
   logic [CNT_W-1:0]  high_len, low_len;
   logic              sig, busy, done, ovf;
   logic [PEND_W-1:0] pend;

   always #5 clk = ~clk;

   pulse_stretcher #(.CNT_W(CNT_W), .PEND_W(PEND_W)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_pulse    (pulse),
      .i_high_len (high_len),
      .i_low_len  (low_len),
      .i_mode     (mode),
      .i_abort    (abort),
      .o_sig      (sig),
      .o_busy     (busy),
      .o_done     (done),
      .o_pend_cnt (pend),
      .o_overflow (ovf)
   );

   wire [5:0] outs = {sig, busy, done, ovf, pend};

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: cycles left in the current high / low phase plus queue depth.
   int m_hi, m_lo, m_pend;
   bit m_done, m_ovf;

   // Per-test observation counters
   int c_rise, c_high, c_adj, c_done, c_ovf, c_maxp;
   bit prev_sig;

   task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [5:0] model_outs();
      return {m_hi > 0, (m_hi > 0) || (m_lo > 0), m_done, m_ovf, PEND_W'(m_pend)};
   endfunction

   task automatic model_reset();
      m_hi = 0; m_lo = 0; m_pend = 0; m_done = 0; m_ovf = 0;
   endtask

   task automatic enqueue();
      if (m_pend == PMAX) m_ovf = 1;
      else m_pend++;
   endtask

   task automatic model_step(input logic p, input logic ab);
      int hh, gg;
      hh = (high_len == 0) ? 1 : int'(high_len);
      gg = (low_len  == 0) ? 1 : int'(low_len);
      m_done = 0; m_ovf = 0;
      if (ab) begin
         m_hi = 0; m_lo = 0; m_pend = 0;
      end else if (m_hi > 0) begin
         if (p && mode) m_hi = hh;
         else begin
            m_hi--;
            if (m_hi == 0) begin m_lo = gg; m_done = 1; end
         end
         if (p && !mode) enqueue();
      end else if (m_lo > 0) begin
         if (p && mode) begin
            m_lo = 0; m_hi = hh;
         end else if (m_lo == 1) begin
            m_lo = 0;
            if (m_pend > 0) begin
               m_hi = hh;
               if (!p) m_pend--;
            end else if (p) m_hi = hh;
         end else begin
            m_lo--;
            if (p) enqueue();
         end
      end else if (p) begin
         m_hi = hh;
      end
   endtask

   task automatic clear_counts();
      c_rise = 0; c_high = 0; c_adj = 0; c_done = 0; c_ovf = 0; c_maxp = 0;
      prev_sig = sig;
   endtask

   // Called at posedge+1: drive, advance one edge, compare at posedge+1.
   task automatic step(input logic p, input logic ab);
      pulse = p; abort = ab;
      @(posedge clk);
      model_step(p, ab);
      #1;
      check_val("cycle_outs", outs, model_outs());
      if (sig && !prev_sig) c_rise++;
      if (sig) c_high++;
      if (sig && prev_sig) c_adj++;
      if (done) c_done++;
      if (ovf) c_ovf++;
      if (int'(pend) > c_maxp) c_maxp = int'(pend);
      prev_sig = sig;
      pulse = 1'b0; abort = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; pulse = 0; abort = 0; mode = 0;
      high_len = 3; low_len = 2;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_outs", outs, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("post_reset_outs", outs, 0);

      // Single strobe, H=3 L=2
      clear_counts();
      idle(3); step(1'b1, 1'b0); idle(8);
      check_val("t1_high_cycles", c_high, 3);
      check_val("t1_done_count", c_done, 1);

      // Three back-to-back strobes, H=2 L=1
      high_len = 2; low_len = 1; clear_counts();
      step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); idle(12);
      check_val("t2_pulses", c_rise, 3);
      check_val("t2_done_count", c_done, 3);
      check_val("t2_max_pend", c_maxp, 2);

      // Saturation with PEND_W=2, H=100
      high_len = 100; low_len = 1; clear_counts();
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      idle(420);
      check_val("t3_pulses", c_rise, 4);
      check_val("t3_overflows", c_ovf, 2);
      check_val("t3_max_pend", c_maxp, 3);

      // Retrigger, H=4: strobes three cycles apart
      mode = 1; high_len = 4; low_len = 2; clear_counts();
      step(1'b1, 1'b0); idle(2); step(1'b1, 1'b0); idle(10);
      check_val("t4_high_cycles", c_high, 7);
      check_val("t4_done_count", c_done, 1);
      check_val("t4_max_pend", c_maxp, 0);

      // Zero lengths with continuous strobes, queue mode
      mode = 0; high_len = 0; low_len = 0; clear_counts();
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      idle(20);
      check_val("t5_adjacent_high", c_adj, 0);
      check_val("t5_high_cycles", c_high, 6);
      check_val("t5_overflows", c_ovf, 0);

      // Length change mid-phase takes effect only at next entry
      high_len = 5; low_len = 3; clear_counts();
      step(1'b1, 1'b0); high_len = 1; low_len = 1; idle(12);
      check_val("t6_high_cycles", c_high, 5);

      // Abort during HIGH with pending=2 and a simultaneous strobe
      high_len = 10; low_len = 2; clear_counts();
      step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); idle(2);
      check_val("t7_pend_before_abort", pend, 2);
      step(1'b1, 1'b1);
      check_val("t7_abort_outs", outs, 0);
      idle(4);
      check_val("t7_done_count", c_done, 0);
      check_val("t7_overflows", c_ovf, 0);

      // Asynchronous reset mid-pulse
      high_len = 6; step(1'b1, 1'b0); idle(2);
      #3 rst_n = 1'b0;
      #1 check_val("async_reset_outs", outs, 0);
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      clear_counts();
      high_len = 2; low_len = 1;
      step(1'b1, 1'b0); idle(5);
      check_val("after_reset_high_cycles", c_high, 2);

      // Randomized segments
      for (int seg = 0; seg < 60; seg++) begin
         mode = 1'($urandom_range(0, 1));
         for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 9) == 0) high_len = CNT_W'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) low_len  = CNT_W'($urandom_range(0, 4));
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 49) == 0));
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
